sa_seq_ctrl: RTL
================

# sa_seq_ctrl

Phase sequencer for the self-attention datapath. It counts the 192-cycle input stream (X with Q weights, then K weights, then V weights), then steps the datapath through the projection, score and output phases. It emits all load, compute and output indices, and issues per-sub-block clock-gate sleep requests. The datapath registers `in_data`/`w_*` one cycle, and every controller output is registered to line up with those input registers.

## Interface
- `DIM`, 8, matrix dimension; weight matrices are DIM×DIM.
- `AW`, 6, load address width, log2(DIM*DIM).
- `clk` in 1 system clock.
- `rst_n` in 1 reset, synchronous, active-low.
- `cg_en` in 1 clock-gating enable for the sleep requests.
- `in_valid` in 1 input stream valid.
- `T` in 4 sequence length, sampled on the first `in_valid` cycle.
- `x_we` out 1 write enable for the X buffer.
- `w_sel` out 2 weight target: 0 none, 1 Q, 2 K, 3 V.
- `ld_addr` out AW load address (row-major).
- `proj_en` out 1; `proj_row` out 3; `proj_col` out 3: Q/K/V element compute.
- `s_en` out 1; `s_row` out 3; `s_col` out 3: score element compute.
- `out_valid` out 1; `o_row` out 3; `o_col` out 3: output element select.
- `sleep_x`, `sleep_w`, `sleep_p`, `sleep_s` out 1 each: gate requests for the X buffer, weight buffers, projection, and score/output blocks.
- `busy` out 1 high when not IDLE; `err` out 1 one-cycle protocol-error pulse.

## Operation
- States: IDLE, LD_Q, LD_K, LD_V, PROJ, SCORE, OUT. `cnt` is 7 bits; `t_reg` is 4 bits.
- IDLE & `in_valid` → LD_Q, `cnt`=0. `t_reg` ← `T` if `T` ∈ {1,4}, otherwise 8.
- LD_Q/LD_K/LD_V: `w_sel`=1/2/3; `ld_addr`=`cnt`[5:0]. `x_we`=1 only in LD_Q with `cnt` < 8·`t_reg`. At `cnt`=63 advance to the next state and clear `cnt`.
- In LD_* at `cnt`=c, `in_valid` must be high, except in LD_V at c=63. If it is low, go to IDLE, pulse `err`, and drop the frame.
- LD_V `cnt`=63 → PROJ.
- PROJ: 8·`t_reg` cycles; `proj_row`=`cnt`/8, `proj_col`=`cnt`%8.
- SCORE: `t_reg`² cycles; `s_row`=`cnt`/`t_reg`, `s_col`=`cnt`%`t_reg`.
- OUT: 8·`t_reg` cycles; `out_valid`=1; `o_row`=`cnt`/8, `o_col`=`cnt`%8; then → IDLE.
- `in_valid` outside IDLE/LD_* is ignored. A new frame can start in the cycle after OUT ends.
- All `*_en`, `we` and index outputs are 0 when their phase is inactive.
- Reset: state IDLE; all outputs 0, including the sleeps; `t_reg`=8.

## Timing
- All outputs are registered from next-state/next-`cnt`. With the first `in_valid` at cycle t0:
  - LD_Q t0+1..t0+64, LD_K t0+65..t0+128, LD_V t0+129..t0+192.
  - PROJ from t0+193 for 8T cycles, then SCORE for T² cycles, then OUT for 8T cycles.
- T=1: first `out_valid` at t0+202, last at t0+209.
- T=8: PROJ t0+193..256, SCORE t0+257..320, `out_valid` t0+321..384.
- `out_valid` is contiguous and never toggles mid-frame.
- `rst_n` low in any state → IDLE on the next edge; a partial frame is discarded and `err` is not pulsed.
- `err` and an IDLE→LD_Q start never coincide. If the abort cycle also has `in_valid`, no new frame starts until `in_valid` is sampled in IDLE.

## Configuration
- `SA_SEQ_CTRL_CG_EN` defined: each sleep output is registered as `cg_en` AND (next state does not use the block):
  - `sleep_x` low in LD_Q and PROJ.
  - `sleep_w` low in LD_* and PROJ.
  - `sleep_p` low in PROJ and SCORE.
  - `sleep_s` low in SCORE and OUT.
  - In IDLE, all four equal `cg_en`.
- Not defined: all sleep outputs are constant 0 and `cg_en` is unused. All other behaviour is identical.

## Test plan
- Reset, then `rst_n`=1 with no `in_valid` → IDLE; all outputs 0; `busy`=0.
- T=1 frame, 192 `in_valid` cycles from t0=10:
  - `x_we` high t0+1..t0+8 only.
  - `w_sel` 1→2→3 at t0+1, t0+65, t0+129.
  - `s_en` for 1 cycle at t0+201.
  - `out_valid` t0+202..t0+209 with `o_col` 0..7.
- T=8 frame → `out_valid` for 64 cycles from t0+321; `o_row`/`o_col` walk 0/0 .. 7/7 row-major; `s_row`/`s_col` walk 0/0 .. 7/7.
- T=5 → treated as 8, same timing as T=8. T=4 → 32 output cycles, SCORE 16 cycles.
- Protocol abort: `in_valid` drops at cnt=20 in LD_K → `err` pulses for one cycle, state returns to IDLE, and no `out_valid` follows. A following legal T=4 frame completes normally.
- With `SA_SEQ_CTRL_CG_EN` and `cg_en`=1:
  - In IDLE, all sleeps are 1.
  - During SCORE, `sleep_x`=`sleep_w`=1 and `sleep_p`=`sleep_s`=0.
  - Assert `rst_n`=0 mid-OUT → next cycle IDLE, `out_valid`=0, sleeps 0.

Source files
------------

// File: rtl/sa_seq_ctrl.sv
// Phase sequencer for the self-attention datapath: load Q/K/V, then projection, score, output.
// Optional clock-gate sleep requests are built when SA_SEQ_CTRL_CG_EN is defined.

// state | meaning
// IDLE  | waiting for the first in_valid of a frame
// LD_Q  | X + Q weight stream (X written for the first 8*t_reg words)
// LD_K  | K weight stream
// LD_V  | V weight stream
// PROJ  | Q/K/V element compute, 8*t_reg cycles
// SCORE | score element compute, t_reg^2 cycles
// OUT   | output element select, 8*t_reg cycles
module sa_seq_ctrl #(
  parameter int DIM = 8,
  parameter int AW  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cg_en,
  input  logic          in_valid,
  input  logic [3:0]    T,
  output logic          x_we,
  output logic [1:0]    w_sel,
  output logic [AW-1:0] ld_addr,
  output logic          proj_en,
  output logic [2:0]    proj_row,
  output logic [2:0]    proj_col,
  output logic          s_en,
  output logic [2:0]    s_row,
  output logic [2:0]    s_col,
  output logic          out_valid,
  output logic [2:0]    o_row,
  output logic [2:0]    o_col,
  output logic          sleep_x,
  output logic          sleep_w,
  output logic          sleep_p,
  output logic          sleep_s,
  output logic          busy,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, LD_Q, LD_K, LD_V, PROJ, SCORE, OUT} state_t;

  localparam logic [6:0] LOAD_LAST = 7'(DIM * DIM - 1);

  state_t     state, nxt_state;
  logic [6:0] cnt, nxt_cnt;
  logic [3:0] t_reg, nxt_t;
  logic       nxt_err;
  logic [6:0] last_row8, last_sq;

  assign last_row8 = {t_reg, 3'b000} - 7'd1;

  // t_reg is only ever 1, 4 or 8
  always_comb begin
    last_sq = 7'd63;
    case (t_reg)
      4'd1:    last_sq = 7'd0;
      4'd4:    last_sq = 7'd15;
      default: last_sq = 7'd63;
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_t     = t_reg;
    nxt_err   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          nxt_state = LD_Q;
          nxt_cnt   = 7'd0;
          nxt_t     = (T == 4'd1 || T == 4'd4) ? T : 4'd8;
        end
      end
      LD_Q, LD_K, LD_V: begin
        // the last V word was presented in the previous cycle, so in_valid is free here
        if (!in_valid && !(state == LD_V && cnt == LOAD_LAST)) begin
          nxt_state = IDLE;
          nxt_cnt   = 7'd0;
          nxt_err   = 1'b1;
        end else if (cnt == LOAD_LAST) begin
          nxt_cnt = 7'd0;
          if (state == LD_Q)      nxt_state = LD_K;
          else if (state == LD_K) nxt_state = LD_V;
          else                    nxt_state = PROJ;
        end else begin
          nxt_cnt = cnt + 7'd1;
        end
      end
      PROJ: begin
        if (cnt == last_row8) begin
          nxt_state = SCORE;
          nxt_cnt   = 7'd0;
        end else begin
          nxt_cnt = cnt + 7'd1;
        end
      end
      SCORE: begin
        if (cnt == last_sq) begin
          nxt_state = OUT;
          nxt_cnt   = 7'd0;
        end else begin
          nxt_cnt = cnt + 7'd1;
        end
      end
      OUT: begin
        if (cnt == last_row8) begin
          nxt_state = IDLE;
          nxt_cnt   = 7'd0;
        end else begin
          nxt_cnt = cnt + 7'd1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = 7'd0;
      end
    endcase
  end

`ifndef SA_SEQ_CTRL_CG_EN
  logic unused_cg_en;
  assign unused_cg_en = cg_en;
`endif

  // outputs decode next-state/next-cnt so they line up with the datapath input registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 7'd0;
      t_reg     <= 4'd8;
      x_we      <= 1'b0;
      w_sel     <= 2'd0;
      ld_addr   <= '0;
      proj_en   <= 1'b0;
      proj_row  <= 3'd0;
      proj_col  <= 3'd0;
      s_en      <= 1'b0;
      s_row     <= 3'd0;
      s_col     <= 3'd0;
      out_valid <= 1'b0;
      o_row     <= 3'd0;
      o_col     <= 3'd0;
      sleep_x   <= 1'b0;
      sleep_w   <= 1'b0;
      sleep_p   <= 1'b0;
      sleep_s   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      t_reg <= nxt_t;
      err   <= nxt_err;
      busy  <= (nxt_state != IDLE);

      x_we    <= (nxt_state == LD_Q) && (nxt_cnt < {nxt_t, 3'b000});
      w_sel   <= 2'd0;
      ld_addr <= '0;
      case (nxt_state)
        LD_Q:    w_sel <= 2'd1;
        LD_K:    w_sel <= 2'd2;
        LD_V:    w_sel <= 2'd3;
        default: w_sel <= 2'd0;
      endcase
      if (nxt_state == LD_Q || nxt_state == LD_K || nxt_state == LD_V)
        ld_addr <= nxt_cnt[AW-1:0];

      proj_en  <= (nxt_state == PROJ);
      proj_row <= (nxt_state == PROJ) ? nxt_cnt[5:3] : 3'd0;
      proj_col <= (nxt_state == PROJ) ? nxt_cnt[2:0] : 3'd0;

      s_en  <= (nxt_state == SCORE);
      s_row <= 3'd0;
      s_col <= 3'd0;
      if (nxt_state == SCORE) begin
        case (nxt_t)
          4'd1: begin
            s_row <= nxt_cnt[2:0];
            s_col <= 3'd0;
          end
          4'd4: begin
            s_row <= {1'b0, nxt_cnt[3:2]};
            s_col <= {1'b0, nxt_cnt[1:0]};
          end
          default: begin
            s_row <= nxt_cnt[5:3];
            s_col <= nxt_cnt[2:0];
          end
        endcase
      end

      out_valid <= (nxt_state == OUT);
      o_row     <= (nxt_state == OUT) ? nxt_cnt[5:3] : 3'd0;
      o_col     <= (nxt_state == OUT) ? nxt_cnt[2:0] : 3'd0;

`ifdef SA_SEQ_CTRL_CG_EN
      sleep_x <= cg_en && !(nxt_state == LD_Q || nxt_state == PROJ);
      sleep_w <= cg_en && !(nxt_state == LD_Q || nxt_state == LD_K ||
                            nxt_state == LD_V || nxt_state == PROJ);
      sleep_p <= cg_en && !(nxt_state == PROJ || nxt_state == SCORE);
      sleep_s <= cg_en && !(nxt_state == SCORE || nxt_state == OUT);
`else
      sleep_x <= 1'b0;
      sleep_w <= 1'b0;
      sleep_p <= 1'b0;
      sleep_s <= 1'b0;
`endif
    end
  end

endmodule
